// File: rtl/tt_ecp5_pkg.sv
// rtl/tt_ecp5_pkg.sv - shared types and default constants for the ECP5 reset sequencer
package tt_ecp5_pkg;

   typedef enum logic [1:0] {
      ST_POR      = 2'd0,
      ST_HOLD     = 2'd1,
      ST_WAIT_REL = 2'd2,
      ST_RUN      = 2'd3
   } state_e;

   localparam int DEF_SYNC_STAGES    = 2;
   localparam int DEF_DEBOUNCE_W     = 16;
   localparam int DEF_POR_CYCLES     = 1024;
   localparam int DEF_MIN_RST_CYCLES = 16;

   // Width of a counter that must reach max(a,b)-1; never narrower than 1 bit.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return ($clog2(m) < 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/tt_ecp5_debounce.sv
// rtl/tt_ecp5_debounce.sv - one-bit synchroniser plus stable-level debounce counter
module tt_ecp5_debounce
   import tt_ecp5_pkg::*;
#(
   parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int   DEBOUNCE_W  = DEF_DEBOUNCE_W,
   parameter logic RST_VAL     = 1'b1
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic db_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [DEBOUNCE_W-1:0]  cnt_q, cnt_d;
   logic                   db_q, db_d;
   logic                   s;

   assign s    = sync_q[SYNC_STAGES-1];
   assign db_o = db_q;

   // A level is accepted only after it has differed for a full 2^DEBOUNCE_W cycles.
   always_comb begin
      cnt_d = '0;
      db_d  = db_q;
      if (s != db_q) begin
         if (&cnt_q) begin
            db_d = s;
         end else begin
            cnt_d = cnt_q + DEBOUNCE_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         cnt_q  <= '0;
         db_q   <= RST_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         cnt_q  <= cnt_d;
         db_q   <= db_d;
      end
   end

endmodule

// File: rtl/tt_ecp5_reset_ctrl.sv
// rtl/tt_ecp5_reset_ctrl.sv - board reset sequencer: lock/button/FPGA reset to clean rst_n,
// plus switch synchronisation and strap capture
module tt_ecp5_reset_ctrl
   import tt_ecp5_pkg::*;
#(
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_W     = DEF_DEBOUNCE_W,
   parameter int POR_CYCLES     = DEF_POR_CYCLES,
   parameter int MIN_RST_CYCLES = DEF_MIN_RST_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       btn_n,
   input  logic [7:0] sw_in,
   output logic       rst_n,
   output logic [7:0] ui_in,
   output logic [7:0] strap,
   output logic       running
);

   localparam int CNT_W = cnt_width(POR_CYCLES, MIN_RST_CYCLES);
   localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_RST_CYCLES - 1);

   logic [SYNC_STAGES-1:0]      lock_sync_q;
   logic [SYNC_STAGES-1:0][7:0] sw_sync_q;
   logic                        lock_s, btn_db;

   state_e                      state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        lost_q, lost_d;
   logic                        rst_n_q, rst_n_d;
   logic [7:0]                  strap_q, strap_d;

   tt_ecp5_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEBOUNCE_W  (DEBOUNCE_W),
      .RST_VAL     (1'b1)
   ) u_btn_db (
      .clk_i (clk),
      .rst_i (rst),
      .d_i   (btn_n),
      .db_o  (btn_db)
   );

   assign lock_s = lock_sync_q[SYNC_STAGES-1];
   assign ui_in  = sw_sync_q[SYNC_STAGES-1];
   assign rst_n  = rst_n_q;
   assign strap  = strap_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_sync_q <= '0;
         sw_sync_q   <= '0;
         state_q     <= ST_POR;
         cnt_q       <= '0;
         lost_q      <= 1'b0;
         rst_n_q     <= 1'b0;
         strap_q     <= 8'h00;
      end else begin
         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
         sw_sync_q   <= {sw_sync_q[SYNC_STAGES-2:0], sw_in};
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         lost_q      <= lost_d;
         rst_n_q     <= rst_n_d;
         strap_q     <= strap_d;
      end
   end

   // lost_q remembers a lock drop seen outside POR, so a brief glitch still forces a full POR rerun.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lost_d  = lost_q | ~lock_s;
      case (state_q)
         ST_POR: begin
            lost_d = 1'b0;
            if (!lock_s) begin
               cnt_d = '0;
            end else if (cnt_q == POR_LAST) begin
               state_d = ST_WAIT_REL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = ST_WAIT_REL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT_REL: begin
            if (!lock_s || lost_q) begin
               state_d = ST_POR;
               cnt_d   = '0;
            end else if (btn_db) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!btn_db || !lock_s) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_POR;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      running = (state_q == ST_RUN);
      rst_n_d = (state_d == ST_RUN);
      strap_d = strap_q;
      if (state_q == ST_WAIT_REL && state_d == ST_RUN) begin
         strap_d = ui_in;
      end
   end

endmodule

// File: tb/tb_tt_ecp5_reset_ctrl.sv
// tb/tb_tt_ecp5_reset_ctrl.sv - directed self-checking bench for tt_ecp5_reset_ctrl
module tb_tt_ecp5_reset_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       pll_locked;
   logic       btn_n;
   logic [7:0] sw_in;
   logic       rst_n;
   logic [7:0] ui_in;
   logic [7:0] strap;
   logic       running;

   int checks   = 0;
   int failures = 0;

   tt_ecp5_reset_ctrl #(
      .SYNC_STAGES    (2),
      .DEBOUNCE_W     (4),
      .POR_CYCLES     (8),
      .MIN_RST_CYCLES (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .btn_n      (btn_n),
      .sw_in      (sw_in),
      .rst_n      (rst_n),
      .ui_in      (ui_in),
      .strap      (strap),
      .running    (running)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; pll_locked = 1'b1; btn_n = 1'b1; sw_in = 8'h5A;
      repeat (4) tick();
      checks++; if (rst_n !== 1'b0) begin failures++; $display("FAIL reset_rst_n got=%b exp=0", rst_n); end
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
      checks++; if (strap !== 8'h00) begin failures++; $display("FAIL reset_strap got=%h exp=00", strap); end
      checks++; if (ui_in !== 8'h00) begin failures++; $display("FAIL reset_ui_in got=%h exp=00", ui_in); end
   endtask

   task automatic test_startup();
      int n;
      rst = 1'b0; sw_in = 8'hA5; n = 0;
      while (rst_n !== 1'b1 && n < 50) begin
         tick();
         n++;
         if (n == 1) begin
            checks++; if (ui_in !== 8'h00) begin failures++; $display("FAIL ui_in_lat1 got=%h exp=00", ui_in); end
         end
         if (n == 2) begin
            checks++; if (ui_in !== 8'hA5) begin failures++; $display("FAIL ui_in_lat2 got=%h exp=a5", ui_in); end
         end
      end
      checks++; if (n != 11) begin failures++; $display("FAIL por_latency got=%0d exp=11", n); end
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL startup_running got=%b exp=1", running); end
      checks++; if (strap !== 8'hA5) begin failures++; $display("FAIL startup_strap got=%h exp=a5", strap); end
   endtask

   task automatic test_switch_change();
      sw_in = 8'h3C;
      tick(); tick();
      checks++; if (ui_in !== 8'h3C) begin failures++; $display("FAIL sw_change_ui_in got=%h exp=3c", ui_in); end
      checks++; if (strap !== 8'hA5) begin failures++; $display("FAIL sw_change_strap got=%h exp=a5", strap); end
   endtask

   task automatic test_bounce();
      int low_cycles;
      low_cycles = 0;
      for (int i = 0; i < 100; i++) begin
         btn_n = ((i / 5) % 2) == 1;
         tick();
         if (rst_n !== 1'b1) low_cycles++;
      end
      btn_n = 1'b1;
      repeat (20) tick();
      checks++; if (low_cycles != 0) begin failures++; $display("FAIL bounce_low_cycles got=%0d exp=0", low_cycles); end
      checks++; if (rst_n !== 1'b1) begin failures++; $display("FAIL bounce_settle_rst_n got=%b exp=1", rst_n); end
   endtask

   task automatic test_press();
      int n, fall, rise;
      btn_n = 1'b0; n = 0; fall = -1; rise = -1;
      while (rise < 0 && n < 200) begin
         tick();
         n++;
         if (n == 20) btn_n = 1'b1;
         if (fall < 0 && rst_n === 1'b0) fall = n;
         else if (fall >= 0 && rise < 0 && rst_n === 1'b1) rise = n;
      end
      checks++; if (fall != 19) begin failures++; $display("FAIL press_fall got=%0d exp=19", fall); end
      checks++; if (rise < 0 || rise - fall < 5) begin failures++; $display("FAIL press_low_width got=%0d exp>=5", rise - fall); end
      checks++; if (rise != 39) begin failures++; $display("FAIL press_rise got=%0d exp=39", rise); end
   endtask

   task automatic test_lock_drop();
      int fall, m;
      pll_locked = 1'b0; fall = -1;
      for (int n = 1; n <= 3; n++) begin
         tick();
         if (fall < 0 && rst_n === 1'b0) fall = n;
      end
      pll_locked = 1'b1;
      checks++; if (fall != 3) begin failures++; $display("FAIL lock_drop_fall got=%0d exp=3", fall); end
      m = 0;
      while (rst_n !== 1'b1 && m < 200) begin
         tick();
         m++;
      end
      checks++; if (m < 8) begin failures++; $display("FAIL relock_low_cycles got=%0d exp>=8", m); end
      checks++; if (rst_n !== 1'b1) begin failures++; $display("FAIL relock_rise got=%b exp=1", rst_n); end
   endtask

   task automatic test_rst_midrun();
      int n;
      rst = 1'b1;
      tick();
      checks++; if (rst_n !== 1'b0) begin failures++; $display("FAIL midrst_rst_n got=%b exp=0", rst_n); end
      checks++; if (strap !== 8'h00) begin failures++; $display("FAIL midrst_strap got=%h exp=00", strap); end
      checks++; if (running !== 1'b0) begin failures++; $display("FAIL midrst_running got=%b exp=0", running); end
      rst = 1'b0; n = 0;
      while (rst_n !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      checks++; if (n != 11) begin failures++; $display("FAIL midrst_por_latency got=%0d exp=11", n); end
      checks++; if (strap !== 8'h3C) begin failures++; $display("FAIL midrst_strap_after got=%h exp=3c", strap); end
      checks++; if (running !== 1'b1) begin failures++; $display("FAIL midrst_running_after got=%b exp=1", running); end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_switch_change();
      test_bounce();
      test_press();
      test_lock_drop();
      test_rst_midrun();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tt_ecp5_reset_ctrl.md
# tt_ecp5_reset_ctrl

Board-level reset sequencer for the ECP5 build, directly upstream of the TT wrapper. It turns FPGA reset, PLL lock and the board's push-button into a clean, glitch-free, minimum-width `rst_n` for the wrapper. It also synchronises the 8 board input switches into `ui_in` and captures a strap snapshot at the moment the design leaves reset.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of every input synchroniser (≥2).
- `DEBOUNCE_W`, 16: debounce counter width; a button level must be stable 2^DEBOUNCE_W cycles before it is accepted.
- `POR_CYCLES`, 1024: reset hold after power-up / PLL lock.
- `MIN_RST_CYCLES`, 16: minimum width of any button- or lock-loss-induced reset.

Ports:
- `clk`  in  1  system clock, same clock fed to the wrapper.
- `rst`  in  1  synchronous, active-high FPGA reset.
- `pll_locked`  in  1  PLL lock, asynchronous; synchronised internally.
- `btn_n`  in  1  board reset button, active low, asynchronous, bouncy.
- `sw_in`  in  8  board switches, asynchronous.
- `rst_n`  out  1  reset to wrapper, active low; registered.
- `ui_in`  out  8  synchronised switches to wrapper.
- `strap`  out  8  `ui_in` value sampled on the last cycle before `rst_n` rises.
- `running`  out  1  high iff the FSM is in RUN.

## Operation
- Synchronisers: `pll_locked`, `btn_n` and each `sw_in` bit pass through `SYNC_STAGES` flops.
  - `ui_in` is the synchronised `sw_in`, with no debounce.
- Debouncer: holds accepted level `btn_db`, reset value 1 (released).
  - When the synchronised button differs from `btn_db`, the counter increments.
  - When the counter reaches all-ones while the input still differs, `btn_db` takes the new level and the counter clears.
  - Any cycle where the input equals `btn_db` clears the counter.
- FSM states: POR, HOLD, WAIT_REL, RUN.
  - POR: counter cleared while synchronised lock is 0. Counts while locked. At count `POR_CYCLES-1`, go to WAIT_REL.
  - RUN: if `btn_db`=0 or lock=0, go to HOLD and clear the counter.
  - HOLD: count to `MIN_RST_CYCLES-1`, then go to WAIT_REL. The count does not depend on the button or lock.
  - WAIT_REL: if lock=0, go to POR. Otherwise, if `btn_db`=1, go to RUN.
- Outputs:
  - `rst_n` = 1 only in RUN. It is registered from the next state, so it rises in the same cycle the state becomes RUN.
  - `strap` loads `ui_in` on the WAIT_REL→RUN transition cycle and is otherwise held.
- Reset values (on `rst`=1): state POR, all counters 0, `btn_db`=1, synchroniser flops 0 (sw) / 1 (btn) / 0 (lock), `rst_n`=0, `strap`=0, `running`=0.
- `rst` asserted mid-operation returns to POR on the next edge, with no partial states.

## Timing
- Lock → `rst_n` high: `SYNC_STAGES` + `POR_CYCLES` + 1 cycles after lock goes high, with the button released.
- Button press seen in RUN: `rst_n` falls `SYNC_STAGES` + 2^DEBOUNCE_W + 1 cycles after a clean press.
- `rst_n` low pulse ≥ `MIN_RST_CYCLES` + 1 cycles, even for a single accepted press.
- Lock loss in RUN: goes to HOLD, then to POR via WAIT_REL. The full `POR_CYCLES` is re-run after relock.
- Lock loss in HOLD: HOLD finishes normally; WAIT_REL then sends the FSM to POR.
- Button held down: the FSM stays in WAIT_REL with `rst_n`=0 indefinitely.
- Simultaneous lock loss and button release in WAIT_REL: lock loss wins, giving POR.
- Bounce shorter than 2^DEBOUNCE_W cycles never changes `btn_db`.

## Structure
- Shared package `tt_ecp5_pkg`: FSM state enum (2 bits) and default parameter constants.
- One sub-module, `tt_ecp5_debounce`: synchroniser plus debounce counter, one bit wide. It is instantiated for the button only.
- Switch and lock synchronisers are inline flop chains.

## Test plan
Bench parameters: `DEBOUNCE_W`=4, `POR_CYCLES`=8, `MIN_RST_CYCLES`=4, `SYNC_STAGES`=2.
- `rst` released with lock=1 from cycle 0 → `rst_n`=0 for exactly 11 cycles, then 1; `running`=1.
- `sw_in`=0xA5 held through startup → `ui_in`=0xA5 two cycles after it is applied; `strap`=0xA5 when `rst_n` rises. Later `sw_in`=0x3C → `ui_in`=0x3C with `strap` still 0xA5.
- In RUN, `btn_n` toggles every 5 cycles for 100 cycles → `rst_n` stays 1 throughout.
- In RUN, a clean 20-cycle press → `rst_n` falls 19 cycles after the press begins. It stays low ≥5 cycles and rises after the debounced release.
- In RUN, lock drops for 3 cycles → `rst_n` falls, then stays low ≥8 cycles after relock before rising.
- `rst` pulsed in RUN → next cycle `rst_n`=0, `strap`=0, and the POR sequence repeats.
